// File: rtl/fill_mem_burst.sv
`default_nettype none
// ============================================================================
// Module      : fill_mem_burst
// Description : Splits the fill stage's single-cycle wide read/write requests
//               into a burst of narrow beats on a ready/valid frame-buffer
//               port, reassembles read beats into one wide word and pulses
//               xfer_done when the burst completes.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_mem_burst #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int BEAT_WORDS      = 8
) (
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        read_enable,
    input  logic                                        write_enable,
    input  logic [ADDR_SIZE_BITS-1:0]                   address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data,
    output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                        busy,
    output logic                                        xfer_done,
    output logic                                        mem_req,
    output logic                                        mem_we,
    output logic [ADDR_SIZE_BITS-1:0]                   mem_addr,
    output logic [WORD_SIZE_BYTES*BEAT_WORDS*8-1:0]     mem_wdata,
    input  logic                                        mem_ready,
    input  logic                                        mem_rvalid,
    input  logic [WORD_SIZE_BYTES*BEAT_WORDS*8-1:0]     mem_rdata
);

    localparam int c_WORD_BITS = WORD_SIZE_BYTES * 8;
    localparam int c_WIDE_BITS = c_WORD_BITS * DATA_SIZE_WORDS;
    localparam int c_BEAT_BITS = c_WORD_BITS * BEAT_WORDS;
    localparam int c_NBEATS    = DATA_SIZE_WORDS / BEAT_WORDS;
    localparam int c_CNT_W     = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_NBEATS - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_BEAT = 3'd1;
    localparam logic [2:0] c_RD_REQ  = 3'd2;
    localparam logic [2:0] c_RD_WAIT = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [c_CNT_W-1:0]        beat_q, beat_d;
    logic [ADDR_SIZE_BITS-1:0] addr_q, addr_d;
    logic [c_WIDE_BITS-1:0]    wdata_q, wdata_d;
    logic [c_WIDE_BITS-1:0]    read_data_q, read_data_d;

    logic [ADDR_SIZE_BITS-1:0] w_beat_offset;
    logic                      w_last_beat;

    // Beat address offset; the add below wraps naturally at the top of memory.
    assign w_beat_offset = ADDR_SIZE_BITS'(beat_q) * ADDR_SIZE_BITS'(BEAT_WORDS);
    assign w_last_beat   = (beat_q == c_LAST_BEAT);

    // Next-state, beat sequencing and read-data assembly.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            c_IDLE: begin
                // A write has priority; a simultaneous read is dropped.
                if (write_enable) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    beat_d  = '0;
                    state_d = c_WR_BEAT;
                end else if (read_enable) begin
                    addr_d  = address;
                    beat_d  = '0;
                    state_d = c_RD_REQ;
                end
            end
            c_WR_BEAT: begin
                if (mem_ready) begin
                    if (w_last_beat) begin
                        state_d = c_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            c_RD_REQ: begin
                // Only one read beat in flight: wait for its data before the next.
                if (mem_ready) begin
                    state_d = c_RD_WAIT;
                end
            end
            c_RD_WAIT: begin
                if (mem_rvalid) begin
                    read_data_d[beat_q*c_BEAT_BITS +: c_BEAT_BITS] = mem_rdata;
                    if (w_last_beat) begin
                        state_d = c_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = c_RD_REQ;
                    end
                end
            end
            c_DONE: begin
                beat_d  = '0;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= c_IDLE;
            beat_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Port-side decode of the current state.
    always_comb begin
        busy      = (state_q != c_IDLE);
        xfer_done = (state_q == c_DONE);
        mem_we    = (state_q == c_WR_BEAT);
        mem_req   = (state_q == c_WR_BEAT) || (state_q == c_RD_REQ);
        mem_addr  = addr_q + w_beat_offset;
        mem_wdata = '0;
        if (state_q == c_WR_BEAT) begin
            mem_wdata = wdata_q[beat_q*c_BEAT_BITS +: c_BEAT_BITS];
        end
    end

    assign read_data = read_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fill_mem_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_fill_mem_burst
// Description : Directed, table-driven bench for fill_mem_burst with a simple
//               frame-buffer model (read word value = its address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fill_mem_burst;

    localparam int AW   = 24;
    localparam int WB   = 24;
    localparam int NW   = 64;
    localparam int BWD  = 8;
    localparam int NB   = NW / BWD;
    localparam int WIDE = WB * NW;
    localparam int BEAT = WB * BWD;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            read_enable = 1'b0;
    logic            write_enable = 1'b0;
    logic [AW-1:0]   address = '0;
    logic [WIDE-1:0] write_data = '0;
    logic [WIDE-1:0] read_data;
    logic            busy;
    logic            xfer_done;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [BEAT-1:0] mem_wdata;
    logic            mem_ready = 1'b1;
    logic            mem_rvalid;
    logic [BEAT-1:0] mem_rdata;

    fill_mem_burst #(
        .ADDR_SIZE_BITS (AW),
        .WORD_SIZE_BYTES(3),
        .DATA_SIZE_WORDS(NW),
        .BEAT_WORDS     (BWD)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .busy        (busy),
        .xfer_done   (xfer_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: logs every accepted beat, answers reads one cycle later.
    int            acc_total = 0;
    logic [AW-1:0] log_addr  [0:1023];
    logic          log_we    [0:1023];
    logic [BEAT-1:0] log_wdata [0:1023];

    function automatic logic [BEAT-1:0] mem_word_pack(input logic [AW-1:0] a);
        logic [BEAT-1:0] r;
        for (int j = 0; j < BWD; j++) r[j*WB +: WB] = a + AW'(j);
        return r;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_req && mem_ready) begin
                log_addr[acc_total]  <= mem_addr;
                log_we[acc_total]    <= mem_we;
                log_wdata[acc_total] <= mem_wdata;
                acc_total            <= acc_total + 1;
                if (!mem_we) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= mem_word_pack(mem_addr);
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [WB-1:0] exp_rd [0:NW-1];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [WB-1:0] seed;
        logic [WB-1:0] mult;
        int            stall_beat;
        int            stall_cycles;
        int            poke;
        int            exp_lat;
    } txn_t;

    txn_t tbl [0:5];

    task automatic run_txn(input txn_t t);
        int              base;
        int              lat;
        int              done_cnt;
        int              stall_left;
        logic [AW-1:0]   ea;
        logic [BEAT-1:0] ew;
        logic [WIDE-1:0] wd;
        for (int k = 0; k < NW; k++) wd[k*WB +: WB] = t.seed + AW'(k) * t.mult;
        base       = acc_total;
        lat        = 0;
        done_cnt   = 0;
        stall_left = t.stall_cycles;
        @(negedge clk);
        write_enable = t.we;
        read_enable  = t.re;
        address      = t.addr;
        write_data   = wd;
        mem_ready    = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) begin
                write_enable = 1'b0;
                read_enable  = 1'b0;
            end
            if (t.poke != 0 && c == t.poke)     read_enable = 1'b1;
            if (t.poke != 0 && c == t.poke + 1) read_enable = 1'b0;
            if (t.we && stall_left > 0 && (acc_total - base) == t.stall_beat) begin
                ea = t.addr + AW'(t.stall_beat * BWD);
                for (int w = 0; w < BWD; w++) ew[w*WB +: WB] = wd[(t.stall_beat*BWD + w)*WB +: WB];
                check("stall_req", 256'(mem_req), 256'(1));
                check("stall_addr", 256'(mem_addr), 256'(ea));
                check("stall_wdata", 256'(mem_wdata), 256'(ew));
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
            if (xfer_done) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
            if (lat != 0 && c >= lat + 3) break;
        end
        mem_ready = 1'b1;
        check("latency", 256'(lat), 256'(t.exp_lat));
        check("done_pulses", 256'(done_cnt), 256'(1));
        check("idle_after", 256'(busy), 256'(0));
        check("beat_count", 256'(acc_total - base), 256'(NB));
        for (int b = 0; b < NB; b++) begin
            ea = t.addr + AW'(b * BWD);
            check("beat_addr", 256'(log_addr[base + b]), 256'(ea));
            check("beat_we", 256'(log_we[base + b]), 256'(t.we));
            if (t.we) begin
                for (int w = 0; w < BWD; w++) ew[w*WB +: WB] = wd[(b*BWD + w)*WB +: WB];
                check("beat_wdata", 256'(log_wdata[base + b]), 256'(ew));
            end
        end
        if (!t.we) begin
            for (int k = 0; k < NW; k++) exp_rd[k] = t.addr + AW'(k);
        end
        for (int k = 0; k < NW; k++) check("read_data", 256'(read_data[k*WB +: WB]), 256'(exp_rd[k]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  256'(busy), 256'(0));
        check({tag, "_done"},  256'(xfer_done), 256'(0));
        check({tag, "_req"},   256'(mem_req), 256'(0));
        check({tag, "_we"},    256'(mem_we), 256'(0));
        check({tag, "_addr"},  256'(mem_addr), 256'(0));
        check({tag, "_wdata"}, 256'(mem_wdata), 256'(0));
        check({tag, "_rdata"}, 256'(read_data == '0), 256'(1));
    endtask

    initial begin
        int   base;
        txn_t post;
        //            we    re    addr        seed        mult       sb  sc  poke lat
        tbl[0] = '{1'b1, 1'b0, 24'h000010, 24'h000000, 24'h000001, -1, 0, 0, 9};
        tbl[1] = '{1'b0, 1'b1, 24'h000100, 24'h000000, 24'h000000, -1, 0, 0, 17};
        tbl[2] = '{1'b1, 1'b0, 24'h000400, 24'h123456, 24'h010203,  2, 3, 0, 12};
        tbl[3] = '{1'b0, 1'b1, 24'hFFFFF8, 24'h000000, 24'h000000, -1, 0, 0, 17};
        tbl[4] = '{1'b1, 1'b1, 24'h000800, 24'hABCDEF, 24'h000011, -1, 0, 4, 9};
        tbl[5] = '{1'b1, 1'b0, 24'hFFFFF0, 24'h777777, 24'h100001,  7, 1, 0, 10};
        post   = '{1'b1, 1'b0, 24'h000040, 24'h0F0F0F, 24'h000101, -1, 0, 0, 9};
        for (int k = 0; k < NW; k++) exp_rd[k] = '0;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Reset while beat 4 of a read is in progress.
        base = acc_total;
        @(negedge clk);
        read_enable = 1'b1;
        address     = 24'h000200;
        @(negedge clk);
        read_enable = 1'b0;
        for (int c = 0; c < 100 && (acc_total - base) < 4; c++) @(negedge clk);
        check("rst_reach_beat4", 256'(acc_total - base), 256'(4));
        check("rst_busy_before", 256'(busy), 256'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int k = 0; k < NW; k++) exp_rd[k] = '0;
        @(negedge clk);
        check("midrst_hold_done", 256'(xfer_done), 256'(0));
        n_rst = 1'b1;
        run_txn(post);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fill_mem_burst.md
Name: fill_mem_burst

Overview:
- Memory-side neighbour of the fill stage. Accepts the fill stage's single-cycle wide requests: `read_enable` or `write_enable`, plus `address`, with the request data or response data on a (WORD_SIZE_BYTES*DATA_SIZE_WORDS*8)-bit bus.
- Executes each request as a burst of fixed-width beats over a narrower frame-buffer port with a ready/valid handshake.
- Returns read data as one wide word.
- Signals completion with a one-cycle `xfer_done` pulse; the fill controller waits on this pulse before issuing its next access.

Parameters:
- ADDR_SIZE_BITS, 24, pixel-word address width.
- WORD_SIZE_BYTES, 3, bytes per pixel word.
- DATA_SIZE_WORDS, 64, pixel words per wide request.
- BEAT_WORDS, 8, pixel words per memory beat; must divide DATA_SIZE_WORDS. NBEATS = DATA_SIZE_WORDS/BEAT_WORDS (default 8).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- read_enable  in  1  wide read request.
- write_enable  in  1  wide write request.
- address  in  ADDR_SIZE_BITS  base pixel-word address of the request.
- write_data  in  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  wide write data; word 0 at LSBs.
- read_data  out  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  wide read data; word 0 at LSBs.
- busy  out  1  high whenever the state is not IDLE.
- xfer_done  out  1  one-cycle pulse at the end of a transfer.
- mem_req  out  1  beat request valid.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_SIZE_BITS  beat address.
- mem_wdata  out  WORD_SIZE_BYTES*BEAT_WORDS*8  beat write data.
- mem_ready  in  1  memory accepts the beat when mem_req && mem_ready.
- mem_rvalid  in  1  read beat data valid.
- mem_rdata  in  WORD_SIZE_BYTES*BEAT_WORDS*8  read beat data.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - state = IDLE; beat counter = 0.
  - read_data, mem_addr, mem_wdata, mem_we, mem_req, busy, xfer_done all 0.
  - Reset mid-burst abandons the transfer: no xfer_done, and partial read data is discarded (read_data cleared).
- States: IDLE, WR_BEAT, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - write_enable=1: latch address and write_data, go to WR_BEAT with beat=0.
  - Otherwise, read_enable=1: latch address, go to RD_REQ with beat=0.
  - Both high: write wins, and read_enable is dropped (not queued).
- Request inputs are ignored in every state except IDLE.
- Beat address: mem_addr = latched_address + beat*BEAT_WORDS, modulo 2^ADDR_SIZE_BITS (wrap at top of memory, no error).
- WR_BEAT:
  - mem_req=1, mem_we=1, mem_wdata = latched write_data slice [beat].
  - Hold mem_req, mem_addr and mem_wdata stable until mem_ready=1.
  - On acceptance: if beat = NBEATS-1, go to DONE; else beat+1.
- RD_REQ:
  - mem_req=1, mem_we=0.
  - On mem_ready: go to RD_WAIT, mem_req=0. Only one read beat is outstanding at a time.
- RD_WAIT:
  - On mem_rvalid: store mem_rdata into read_data slice [beat].
  - Then, if last beat, go to DONE; else beat+1 and return to RD_REQ.
  - mem_rvalid outside RD_WAIT is ignored.
- DONE: xfer_done=1 for exactly one cycle, busy=1, then go to IDLE.
- read_data:
  - Changes only as beats are written in during a read.
  - Holds its value between transfers; write transfers leave it untouched.
- Requester obligation: deassert the enable by the DONE cycle. An enable still high in IDLE starts a new transfer.
- Latency, with mem_ready tied 1 and mem_rvalid 1 cycle after acceptance:
  - Write: enable sampled at edge E; DONE is the cycle after edge E+NBEATS; xfer_done after 1+NBEATS cycles (9 at defaults).
  - Read: xfer_done after 1+2*NBEATS cycles (17 at defaults).
- Beat counter width is clog2(NBEATS), minimum 1.

Test Plan:
- Write, mem_ready=1, address=0x000010, write_data word k = k → 8 beats at mem_addr 0x10, 0x18 … 0x48; beat 0 mem_wdata words 0..7; xfer_done exactly once, 9 cycles after the enable edge.
- Read, memory model returns word value = its address, rvalid 1 cycle after acceptance, address=0x000100 → read_data word k = 0x100+k; xfer_done at cycle 17; read_data stable afterwards.
- Backpressure: mem_ready low for 3 cycles on beat 2 of a write → mem_req, mem_addr and mem_wdata held constant through the stall; total latency 12 cycles.
- Wrap: address=0xFFFFF8, read → beat 0 at 0xFFFFF8, beat 1 at 0x000000; all 8 beats complete.
- Simultaneous read_enable=write_enable=1 → write burst only (mem_we=1 on every beat); read_enable pulsed again while busy is ignored.
- n_rst asserted during beat 4 of a read → all outputs 0 immediately; after release, a new write completes normally.
